// File: rtl/eth_arb_pkg.sv
// Shared types and counter widths for the Ethernet TX frame arbiter.
package eth_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      ABORT = 2'd2
   } arb_state_t;

   localparam int FRAME_CNT_W = 32;
   localparam int ABORT_CNT_W = 16;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_priority_select #(
   parameter int NUM_PORTS = 4,
   parameter int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] request,
   input  logic [IDX_W-1:0]     last_grant,
   output logic [NUM_PORTS-1:0] grant
);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      // Offset 1 first, offset NUM_PORTS (last_grant itself) last.
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = IDX_W'((int'(last_grant) + i) % NUM_PORTS);
         if (!found && request[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter of AXI-Stream requesters onto the MAC TX stream,
// with mid-frame idle timeout that emits an error-tagged abort beat and drains the source.
module eth_tx_frame_arbiter
   import eth_arb_pkg::*;
#(
   parameter int NUM_PORTS      = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_PORTS-1:0]            s_tvalid,
   output logic [NUM_PORTS-1:0]            s_tready,
   input  logic [NUM_PORTS-1:0]            s_tlast,
   input  logic [NUM_PORTS-1:0]            s_tuser,
   output logic [DATA_WIDTH-1:0]           m_tdata,
   output logic                            m_tvalid,
   input  logic                            m_tready,
   output logic                            m_tlast,
   output logic                            m_tuser,
   input  logic [NUM_PORTS-1:0]            port_enable,
   output logic [NUM_PORTS-1:0]            grant,
   output logic [FRAME_CNT_W-1:0]          frame_count,
   output logic [ABORT_CNT_W-1:0]          abort_count,
   output logic [1:0]                      dbg_state
);

   localparam int IDX_W = $clog2(NUM_PORTS);
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   arb_state_t             state_q, state_d;
   logic [NUM_PORTS-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]       gidx_q, gidx_d;
   logic [IDX_W-1:0]       last_grant_q, last_grant_d;
   logic [NUM_PORTS-1:0]   drain_q, drain_d;
   logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [ABORT_CNT_W-1:0] abort_cnt_q, abort_cnt_d;

   logic [NUM_PORTS-1:0]   request;
   logic [NUM_PORTS-1:0]   rr_sel;
   logic [IDX_W-1:0]       sel_idx;

   assign request = s_tvalid & port_enable & ~drain_q;

   rr_priority_select #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_rr (
      .request    (request),
      .last_grant (last_grant_q),
      .grant      (rr_sel)
   );

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (rr_sel[i]) sel_idx = IDX_W'(i);
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      gidx_d       = gidx_q;
      last_grant_d = last_grant_q;
      idle_cnt_d   = idle_cnt_q;
      frame_cnt_d  = frame_cnt_q;
      abort_cnt_d  = abort_cnt_q;
      // Draining ports swallow beats regardless of FSM state until their tlast.
      drain_d      = drain_q & ~(s_tvalid & s_tlast);
      s_tready     = drain_q;
      m_tvalid     = 1'b0;
      m_tdata      = '0;
      m_tlast      = 1'b0;
      m_tuser      = 1'b0;

      case (state_q)
         IDLE: begin
            idle_cnt_d = '0;
            if (|request) begin
               grant_d = rr_sel;
               gidx_d  = sel_idx;
               state_d = PASS;
            end
         end

         PASS: begin
            m_tdata          = s_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
            m_tvalid         = s_tvalid[gidx_q];
            m_tlast          = s_tlast[gidx_q];
            m_tuser          = s_tuser[gidx_q];
            s_tready[gidx_q] = m_tready;
            if (m_tvalid && m_tready && m_tlast) begin
               frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
               last_grant_d = gidx_q;
               grant_d      = '0;
               idle_cnt_d   = '0;
               state_d      = IDLE;
            end else if (TIMEOUT_CYCLES > 0) begin
               if (s_tvalid[gidx_q]) begin
                  idle_cnt_d = '0;
               end else if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  idle_cnt_d = '0;
                  state_d    = ABORT;
               end else begin
                  idle_cnt_d = idle_cnt_q + CNT_W'(1);
               end
            end
         end

         ABORT: begin
            m_tvalid = 1'b1;
            m_tlast  = 1'b1;
            m_tuser  = 1'b1;
            if (m_tready) begin
               drain_d[gidx_q] = 1'b1;
               if (abort_cnt_q != {ABORT_CNT_W{1'b1}}) begin
                  abort_cnt_d = abort_cnt_q + ABORT_CNT_W'(1);
               end
               last_grant_d = gidx_q;
               grant_d      = '0;
               state_d      = IDLE;
            end
         end

         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         gidx_q       <= '0;
         last_grant_q <= IDX_W'(NUM_PORTS - 1);
         drain_q      <= '0;
         idle_cnt_q   <= '0;
         frame_cnt_q  <= '0;
         abort_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         gidx_q       <= gidx_d;
         last_grant_q <= last_grant_d;
         drain_q      <= drain_d;
         idle_cnt_q   <= idle_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         abort_cnt_q  <= abort_cnt_d;
      end
   end

   assign grant       = grant_q;
   assign frame_count = frame_cnt_q;
   assign abort_count = abort_cnt_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: expected output beats (grant, tlast, tuser, tdata)
// are queued as stimulus is planned and popped when the MAC side handshakes.
module tb_eth_tx_frame_arbiter;
   import eth_arb_pkg::*;

   localparam int NP = 4;
   localparam int DW = 8;
   localparam int TO = 1024;
   localparam int EW = NP + 2 + DW;

   // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
   // A beat moves on a rising edge where tvalid and tready are both high.
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset_n;
   logic [NP*DW-1:0]     s_tdata;
   logic [NP-1:0]        s_tvalid, s_tready, s_tlast, s_tuser;
   logic [DW-1:0]        m_tdata;
   logic                 m_tvalid, m_tready, m_tlast, m_tuser;
   logic [NP-1:0]        port_enable, grant;
   logic [31:0]          frame_count;
   logic [15:0]          abort_count;
   logic [1:0]           dbg_state;

   logic [EW-1:0] exp_q[$];
   int  checks = 0;
   int  errors = 0;
   bit  chk_gap = 1'b0;

   eth_tx_frame_arbiter #(
      .NUM_PORTS      (NP),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .s_tdata     (s_tdata),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tlast     (s_tlast),
      .s_tuser     (s_tuser),
      .m_tdata     (m_tdata),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .m_tlast     (m_tlast),
      .m_tuser     (m_tuser),
      .port_enable (port_enable),
      .grant       (grant),
      .frame_count (frame_count),
      .abort_count (abort_count),
      .dbg_state   (dbg_state)
   );

   function automatic logic [DW-1:0] beat_val(int p, int b);
      return DW'((p << 6) | (b & 63));
   endfunction

   function automatic logic [EW-1:0] mk_exp(int g, bit last, bit user, logic [DW-1:0] d);
      return {NP'(1 << g), last, user, d};
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(int p, int b0, int n, bit with_last);
      for (int b = b0; b < b0 + n; b++) begin
         exp_q.push_back(mk_exp(p, with_last && (b == b0 + n - 1), 1'b0, beat_val(p, b)));
      end
   endtask

   task automatic send_beats(int p, int b0, int n, bit with_last);
      bit hs;
      int t;
      for (int b = b0; b < b0 + n; b++) begin
         s_tdata[p*DW +: DW] = beat_val(p, b);
         s_tvalid[p]         = 1'b1;
         s_tlast[p]          = with_last && (b == b0 + n - 1);
         s_tuser[p]          = 1'b0;
         hs = 1'b0;
         t  = 0;
         while (!hs && t < 4000) begin
            @(negedge clk);
            hs = s_tvalid[p] & s_tready[p];
            @(posedge clk);
            #1;
            t++;
         end
         if (!hs) check($sformatf("handshake_timeout_p%0d", p), 32'(hs), 32'd1);
      end
      s_tvalid[p] = 1'b0;
      s_tlast[p]  = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic monitor();
      logic [EW-1:0] e;
      bit prev_last = 1'b0;
      int cyc       = 0;
      int end_cyc   = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!chk_gap) prev_last = 1'b0;
         if (reset_n && m_tvalid && m_tready) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("beat", 32'({grant, m_tlast, m_tuser, m_tdata}), 32'(e));
            end
            if (chk_gap && prev_last) check("bubble_cycles", 32'(cyc - end_cyc), 32'd2);
            prev_last = m_tlast;
            if (m_tlast) end_cyc = cyc;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int g0_hits;
      bit done;

      reset_n     = 1'b0;
      s_tdata     = '0;
      s_tvalid    = '0;
      s_tlast     = '0;
      s_tuser     = '0;
      m_tready    = 1'b0;
      port_enable = '1;

      fork
         monitor();
      join_none

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_s_tready", 32'(s_tready), 32'd0);
      check("rst_frame_count", frame_count, 32'd0);
      check("rst_abort_count", 32'(abort_count), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      @(posedge clk);
      #1;
      reset_n  = 1'b1;
      m_tready = 1'b1;

      // Ports 0 and 2 contend: port 0 first, one bubble between frames
      chk_gap = 1'b1;
      push_frame(0, 0, 3, 1'b1);
      push_frame(2, 0, 3, 1'b1);
      fork
         send_beats(0, 0, 3, 1'b1);
         send_beats(2, 0, 3, 1'b1);
      join
      wait_drain();
      check("frame_count_two", frame_count, 32'd2);
      chk_gap = 1'b0;

      // All four ports continuously valid, ten frames in round-robin order
      do_reset();
      chk_gap = 1'b1;
      for (int k = 0; k < 10; k++) push_frame(k % NP, 0, 2, 1'b1);
      fork
         begin for (int f = 0; f < 3; f++) send_beats(0, 0, 2, 1'b1); end
         begin for (int f = 0; f < 3; f++) send_beats(1, 0, 2, 1'b1); end
         begin for (int f = 0; f < 2; f++) send_beats(2, 0, 2, 1'b1); end
         begin for (int f = 0; f < 2; f++) send_beats(3, 0, 2, 1'b1); end
      join
      wait_drain();
      check("frame_count_ten", frame_count, 32'd10);
      chk_gap = 1'b0;

      // Port 1 stalls mid-frame: abort after TO idle cycles, then drain
      push_frame(1, 0, 2, 1'b0);
      exp_q.push_back(mk_exp(1, 1'b1, 1'b1, '0));
      send_beats(1, 0, 2, 1'b0);
      m_tready = 1'b0;
      cnt = 0;
      while (cnt < TO + 100) begin
         @(negedge clk);
         if (m_tvalid) break;
         cnt++;
      end
      check("timeout_cycles", 32'(cnt), 32'(TO));
      check("abort_state", 32'(dbg_state), 32'(ABORT));
      check("abort_s_tready", 32'(s_tready), 32'd0);
      repeat (3) @(negedge clk);
      check("abort_hold_valid", 32'({m_tvalid, m_tlast, m_tuser, m_tdata}), 32'({1'b1, 1'b1, 1'b1, 8'h00}));
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_count_one", 32'(abort_count), 32'd1);
      check("post_abort_grant", 32'(grant), 32'd0);
      check("drain_s_tready", 32'(s_tready), 32'b0010);
      @(posedge clk);
      #1;
      send_beats(1, 2, 3, 1'b1);
      @(negedge clk);
      check("drain_cleared", 32'(s_tready), 32'd0);
      check("frame_count_no_abort", frame_count, 32'd10);
      push_frame(1, 0, 2, 1'b1);
      send_beats(1, 0, 2, 1'b1);
      wait_drain();
      check("frame_count_after_drain", frame_count, 32'd11);

      // 64-beat frame with m_tready toggling every cycle
      push_frame(2, 0, 64, 1'b1);
      done = 1'b0;
      fork
         begin
            send_beats(2, 0, 64, 1'b1);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               m_tready = ~m_tready;
            end
         end
      join
      m_tready = 1'b1;
      wait_drain();
      check("frame_count_long", frame_count, 32'd12);

      // Disabling port 0 mid-frame lets the frame finish, then masks it
      push_frame(0, 0, 6, 1'b1);
      send_beats(0, 0, 2, 1'b0);
      port_enable = 4'b1110;
      send_beats(0, 2, 4, 1'b1);
      wait_drain();
      check("frame_count_disabled_port", frame_count, 32'd13);
      @(posedge clk);
      #1;
      s_tdata[0 +: DW] = beat_val(0, 0);
      s_tvalid[0]      = 1'b1;
      push_frame(3, 0, 2, 1'b1);
      send_beats(3, 0, 2, 1'b1);
      g0_hits = 0;
      repeat (20) begin
         @(negedge clk);
         if (grant[0] || s_tready[0]) g0_hits++;
      end
      check("port0_masked", 32'(g0_hits), 32'd0);
      @(posedge clk);
      #1;
      s_tvalid[0] = 1'b0;
      port_enable = '1;
      wait_drain();
      check("frame_count_port3", frame_count, 32'd14);

      // Reset mid-frame on port 2 after port 0 was last served
      @(posedge clk);
      #1;
      push_frame(0, 0, 2, 1'b1);
      send_beats(0, 0, 2, 1'b1);
      s_tdata[2*DW +: DW] = beat_val(2, 0);
      s_tvalid[2]         = 1'b1;
      for (int k = 0; k < 3; k++) exp_q.push_back(mk_exp(2, 1'b0, 1'b0, beat_val(2, 0)));
      repeat (4) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_queue", 32'(exp_q.size()), 32'd0);
      check("midrst_grant", 32'(grant), 32'd0);
      check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("midrst_s_tready", 32'(s_tready), 32'd0);
      check("midrst_frame_count", frame_count, 32'd0);
      check("midrst_abort_count", 32'(abort_count), 32'd0);
      check("midrst_state", 32'(dbg_state), 32'(IDLE));
      s_tvalid[2] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      push_frame(0, 0, 2, 1'b1);
      push_frame(3, 0, 2, 1'b1);
      fork
         send_beats(0, 0, 2, 1'b1);
         send_beats(3, 0, 2, 1'b1);
      join
      wait_drain();
      check("frame_count_after_reset", frame_count, 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
